// File: rtl/bitser_pkg.sv
// rtl/bitser_pkg.sv - shared word width and state encoding for the bit serializer
package bitser_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/par_gen16.sv
// rtl/par_gen16.sv - even parity (XOR reduce) of a 16-bit word
module par_gen16
    import bitser_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    output logic              parity
);

    assign parity = ^data;

endmodule

// File: rtl/bitser_tx.sv
// rtl/bitser_tx.sv - 16-bit parallel-to-serial transmitter with optional even-parity beat
module bitser_tx
    import bitser_pkg::*;
#(
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              lsb_first,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_sof,
    output logic              ser_eof
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [WORD_W-1:0] shreg;
    logic              lsb_q;
    logic              par_q;
    logic              par_in;
    logic              accept;
    logic              last_data;

    par_gen16 u_par_gen16 (
        .data   (in_data),
        .parity (par_in)
    );

    assign accept    = (state == IDLE) && in_valid;
    assign last_data = (cnt == 4'(WORD_W - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_sof   = 1'b0;
        ser_eof   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                // The shift register moves toward the output end, so the beat is always at an edge bit.
                ser_out   = lsb_q ? shreg[0] : shreg[WORD_W-1];
                ser_sof   = (cnt == 4'd0);
                ser_eof   = !PARITY_EN && last_data;
                if (ser_ready && last_data) begin
                    state_nxt = PARITY_EN ? PARITY : IDLE;
                end
            end
            PARITY: begin
                ser_valid = 1'b1;
                ser_out   = par_q;
                ser_eof   = 1'b1;
                if (ser_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            shreg <= '0;
            lsb_q <= 1'b0;
            par_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg <= in_data;
                lsb_q <= lsb_first;
                par_q <= par_in;
                cnt   <= 4'd0;
            end else if (state == SHIFT && ser_ready) begin
                shreg <= lsb_q ? {1'b0, shreg[WORD_W-1:1]} : {shreg[WORD_W-2:0], 1'b0};
                cnt   <= last_data ? 4'd0 : cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bitser_tx.sv
// tb/tb_bitser_tx.sv - scoreboard bench for bitser_tx with and without the parity beat
module tb_bitser_tx;

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data [2];
    logic [1:0]  in_valid = 2'b00;
    logic [1:0]  lsb_first = 2'b00;
    logic [1:0]  in_ready;
    logic [1:0]  ser_out;
    logic [1:0]  ser_valid;
    logic [1:0]  ser_sof;
    logic [1:0]  ser_eof;
    logic [1:0]  ser_ready;
    logic [1:0]  rnd_en = 2'b00;
    logic [1:0]  rnd_val = 2'b11;
    logic [1:0]  man_val = 2'b11;

    bit    checking = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    beat_t q [2][$];

    assign ser_ready = (rnd_en & rnd_val) | (~rnd_en & man_val);

    bitser_tx #(.PARITY_EN(1'b1)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data[0]),
        .in_valid  (in_valid[0]),
        .lsb_first (lsb_first[0]),
        .in_ready  (in_ready[0]),
        .ser_out   (ser_out[0]),
        .ser_valid (ser_valid[0]),
        .ser_ready (ser_ready[0]),
        .ser_sof   (ser_sof[0]),
        .ser_eof   (ser_eof[0])
    );

    bitser_tx #(.PARITY_EN(1'b0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data[1]),
        .in_valid  (in_valid[1]),
        .lsb_first (lsb_first[1]),
        .in_ready  (in_ready[1]),
        .ser_out   (ser_out[1]),
        .ser_valid (ser_valid[1]),
        .ser_ready (ser_ready[1]),
        .ser_sof   (ser_sof[1]),
        .ser_eof   (ser_eof[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Reference frame: the word's bits in the requested order, then an optional parity beat.
    task automatic push_frame(input int i, input logic [15:0] d, input logic l);
        beat_t bt;
        bit    pe;
        pe = (i == 0);
        for (int k = 0; k < 16; k++) begin
            bt.b   = l ? d[k] : d[15-k];
            bt.sof = (k == 0);
            bt.eof = !pe && (k == 15);
            q[i].push_back(bt);
        end
        if (pe) begin
            bt.b   = logic'($countones(d) % 2);
            bt.sof = 1'b0;
            bt.eof = 1'b1;
            q[i].push_back(bt);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                bit busy;
                busy = (q[i].size() != 0);
                chk("in_ready", i, 32'(in_ready[i]), 32'(!busy));
                chk("ser_valid", i, 32'(ser_valid[i]), 32'(busy));
                if (busy) begin
                    chk("beat", i, 32'({ser_out[i], ser_sof[i], ser_eof[i]}), 32'(q[i][0]));
                end else begin
                    chk("idle_outs", i, 32'({ser_out[i], ser_sof[i], ser_eof[i]}), 32'd0);
                end
                if (rst) begin
                    q[i].delete();
                end else if (busy) begin
                    if (ser_ready[i]) begin
                        void'(q[i].pop_front());
                    end
                end else if (in_valid[i]) begin
                    push_frame(i, in_data[i], lsb_first[i]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_val = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        end
    end

    task automatic send(input int i, input logic [15:0] d, input logic l, input bit keep);
        int n;
        n = 0;
        in_data[i]   = d;
        lsb_first[i] = l;
        in_valid[i]  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready[i] && !rst) break;
            n++;
            if (n > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout dut%0d got no in_ready expected in_ready=1", i);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid[i] = 1'b0;
        // Scramble the inputs mid-frame; the latched word must be unaffected.
        in_data[i]   = 16'($urandom);
        lsb_first[i] = 1'($urandom);
    endtask

    initial begin
        in_data[0] = 16'h0;
        in_data[1] = 16'h0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid[0] = 1'b0;

        send(0, 16'h8001, 1'b0, 1'b0);
        send(0, 16'h0003, 1'b1, 1'b0);
        send(0, 16'h0007, 1'b0, 1'b0);
        send(1, 16'hFFFF, 1'b0, 1'b0);

        send(0, 16'h1234, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        man_val[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        man_val[0] = 1'b1;

        send(0, 16'hC3A6, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 16'h0F1E, 1'b0, 1'b0);

        send(0, 16'hA5A5, 1'b0, 1'b1);
        send(0, 16'h5A5A, 1'b0, 1'b0);

        rnd_en = 2'b11;
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    send(0, 16'($urandom), 1'($urandom), (n < 24) && ($urandom_range(0, 1) == 1));
                end
            end
            begin
                for (int n = 0; n < 20; n++) begin
                    send(1, 16'($urandom), 1'($urandom), (n < 19) && ($urandom_range(0, 1) == 1));
                end
            end
        join

        begin
            int n;
            n = 0;
            while ((q[0].size() != 0 || q[1].size() != 0) && n < 500) begin
                @(posedge clk);
                n++;
            end
            if (n >= 500) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout got %0d/%0d beats left expected 0", q[0].size(), q[1].size());
            end
        end
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bitser_tx.md
BITSER_TX -- requirements
Module: bitser_tx

Interface
REQ-001 SHALL have parameter PARITY_EN, default 1: 1 appends an even-parity beat after the data; 0 sends data only.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_data  input  16  parallel word to transmit.
REQ-005 SHALL have port in_valid  input  1  in_data and lsb_first are valid.
REQ-006 SHALL have port lsb_first  input  1  bit order: 0 sends bit 15 first, 1 sends bit 0 first.
REQ-007 SHALL have port in_ready  output  1  the block can accept a word.
REQ-008 SHALL have port ser_out  output  1  current serial bit.
REQ-009 SHALL have port ser_valid  output  1  ser_out holds a valid beat.
REQ-010 SHALL have port ser_ready  input  1  downstream accepts the beat.
REQ-011 SHALL have port ser_sof  output  1  current beat is the first data bit of a frame.
REQ-012 SHALL have port ser_eof  output  1  current beat is the last beat of a frame (parity beat when PARITY_EN=1).

Function
REQ-013 SHALL implement states IDLE, SHIFT and PARITY (PARITY exists only when PARITY_EN=1).
REQ-014 SHALL drive in_ready=1 only in IDLE; a word is accepted at a clock edge where in_valid=1 and in_ready=1.
REQ-015 SHALL, on accept, latch in_data, lsb_first and the even parity (XOR of all 16 bits), load bit counter=0, and enter SHIFT.
REQ-016 SHALL present the first beat in the cycle after accept (latency 1), with ser_valid=1 and ser_sof=1.
REQ-017 SHALL transfer a beat at each edge where ser_valid=1 and ser_ready=1, then advance the counter by 1.
REQ-018 SHALL present beat k (k=0..15) as in_data[15-k] when lsb_first=0 and as in_data[k] when lsb_first=1.
REQ-019 SHALL hold ser_out, ser_sof and ser_eof stable while ser_valid=1 and ser_ready=0; in_data and lsb_first changes during a frame SHALL have no effect.
REQ-020 SHALL, when beat 15 transfers, go to PARITY if PARITY_EN=1, or to IDLE if PARITY_EN=0 (ser_eof=1 on beat 15 in that case).
REQ-021 SHALL, in PARITY, drive ser_out=latched parity and ser_eof=1, and go to IDLE when that beat transfers.
REQ-022 SHALL drive ser_valid=0 and ser_out=0 in IDLE; ser_sof and ser_eof SHALL be 0 whenever ser_valid=0.
REQ-023 SHALL produce back-to-back frames with exactly one IDLE cycle between the last beat of one frame and the first beat of the next; the counter SHALL never wrap past 15.
REQ-024 SHALL give no frame and accept no word in the cycle where rst=1, even if in_valid=1.

Reset
REQ-025 SHALL, at any edge with rst=1, enter IDLE, clear the counter, shift register and parity, and abandon any frame in progress.
REQ-026 SHALL present outputs after reset as: in_ready=1, ser_valid=0, ser_out=0, ser_sof=0, ser_eof=0.

Structure
REQ-027 SHALL take the state encoding (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2) and WORD_W=16 from the shared package bitser_pkg.
REQ-028 SHALL place parity in one sub-module, par_gen16 (16-bit XOR reduce); the FSM, counter and shift register SHALL stay in bitser_tx.

Verification
REQ-029 SHALL cover: 0x8001, lsb_first=0, ser_ready=1 -> beats 1,0x14,1, then parity 0 with eof; sof on beat 0; 17 beats total.
REQ-030 SHALL cover: 0x0003, lsb_first=1 -> beats 1,1,0x14, then parity 0; 0x0007 -> parity beat 1.
REQ-031 SHALL cover: ser_ready=0 during frame beats 3-5 -> ser_out and flags held; frame completes with no beat lost or duplicated.
REQ-032 SHALL cover: rst=1 at beat 8 -> next cycle ser_valid=0 and in_ready=1; the next word sends from beat 0 with sof.
REQ-033 SHALL cover: in_valid held high with 0xA5A5 then 0x5A5A -> one idle cycle between frames; in_ready=0 during each frame.
REQ-034 SHALL cover: PARITY_EN=0, 0xFFFF -> 16 beats of 1 with eof on beat 15; no parity beat.
